// File: rtl/memory_responder_pkg.sv
// Shared definitions for the adding-machine CPU memory path: default widths,
// responder FSM state codes and the wait-counter preload helper.
package memory_responder_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;
   localparam int WAIT_W     = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   // Counter value loaded on acceptance; WAIT exits when it reaches zero.
   function automatic logic [WAIT_W-1:0] wait_load(input int ws);
      return (ws > 0) ? WAIT_W'(ws - 1) : '0;
   endfunction

endpackage

// File: rtl/memory_responder_if.sv
// CPU <-> memory responder bus: level request/handshake signals plus the
// side-band preload port used by loaders and benches.
interface memory_responder_if
   import memory_responder_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              mem_ready;
   logic              mem_error;
   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   logic [DATA_W-1:0] init_data;

   modport master (
      output mem_read,
      output mem_write,
      output addr,
      output data_in,
      output init_we,
      output init_addr,
      output init_data,
      input  data_out,
      input  mem_ready,
      input  mem_error
   );

   modport slave (
      input  mem_read,
      input  mem_write,
      input  addr,
      input  data_in,
      input  init_we,
      input  init_addr,
      input  init_data,
      output data_out,
      output mem_ready,
      output mem_error
   );

endinterface

// File: rtl/memory_responder_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, registered read port whose
// output register is the CPU-facing data_out (cleared by reset, array is not).
module memory_responder_mem_array
   import memory_responder_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 32,
   parameter int IDX_W  = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic              rclr,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register holds between reads; an out-of-range read returns zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= rclr ? '0 : mem[raddr];
      end
   end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: accepts level read/write requests, inserts WAIT_STATES
// wait cycles, performs the access on leaving DONE and pulses mem_ready/mem_error.
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 1
) (
   input logic               clock,
   input logic               reset,
   memory_responder_if.slave bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t            state;
   logic [WAIT_W-1:0] cnt;
   logic              ready_p1;
   logic              error_p1;

   logic [ADDR_W-1:0] addr_p0;
   logic [DATA_W-1:0] wdata_p0;
   logic              op_p0;

   logic              req_one;
   logic              req_both;
   logic              in_idle;
   logic              in_done;
   logic              hit_p0;
   logic              init_hit;

   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   assign req_one  = bus.mem_read ^ bus.mem_write;
   assign req_both = bus.mem_read & bus.mem_write;
   assign in_idle  = (state == ST_IDLE);
   assign in_done  = (state == ST_DONE);
   assign hit_p0   = in_range(addr_p0);
   assign init_hit = bus.init_we & in_range(bus.init_addr);

   // Stage p0 -> p1: FSM, wait counter and one-cycle completion/error pulses
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         ready_p1 <= 1'b0;
         error_p1 <= 1'b0;
      end else begin
         ready_p1 <= 1'b0;
         error_p1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_one) begin
                  if (WAIT_STATES == 0) begin
                     state <= ST_DONE;
                  end else begin
                     cnt   <= wait_load(WAIT_STATES);
                     state <= ST_WAIT;
                  end
               end else if (req_both) begin
                  error_p1 <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               ready_p1 <= 1'b1;
               error_p1 <= ~hit_p0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Stage p0: request capture at acceptance; later changes on the bus are ignored
   always_ff @(posedge clock) begin
      if (in_idle && req_one) begin
         addr_p0  <= bus.addr;
         wdata_p0 <= bus.data_in;
         op_p0    <= bus.mem_write ? OP_WRITE : OP_READ;
      end
   end

   // DONE-write and init never coincide: init only lands while IDLE.
   assign mem_we    = (in_done & (op_p0 == OP_WRITE) & hit_p0) | (in_idle & init_hit);
   assign mem_waddr = in_done ? addr_p0[IDX_W-1:0] : bus.init_addr[IDX_W-1:0];
   assign mem_wdata = in_done ? wdata_p0 : bus.init_data;
   assign mem_re    = in_done & (op_p0 == OP_READ);

   memory_responder_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clock  (clock),
      .reset  (reset),
      .we     (mem_we),
      .waddr  (mem_waddr),
      .wdata  (mem_wdata),
      .re     (mem_re),
      .rclr   (~hit_p0),
      .raddr  (addr_p0[IDX_W-1:0]),
      .rdata  (bus.data_out)
   );

   assign bus.mem_ready = ready_p1;
   assign bus.mem_error = error_p1;

endmodule
